// File: rtl/hsiao_code_decoder.sv
// hsiao_code_decoder: two-stage SEC-DED decoder for a 13-bit (8 data) codeword
// with valid/ready handshake and optional saturating error counters.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      input handshake, in_code[12:0] received codeword
//   out_valid/out_ready    output handshake
//   out_data[7:0]          corrected data (raw data on uncorrectable error)
//   out_sec/out_ded        single corrected / uncorrectable flags
//   out_syndrome[3:0]      {s8,s4,s2,s1}
//   cnt_clr                synchronous clear of both counters
//   sec_cnt/ded_cnt        saturating error counts (CNT_W bits)
//
// Optional feature macro: HSIAO_ERR_CNT_EN enables the error counters;
// without it sec_cnt/ded_cnt are tied to 0 and cnt_clr is ignored.

module hsiao_code_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [12:0]      in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_sec,
  output logic             out_ded,
  output logic [3:0]       out_syndrome,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sec_cnt,
  output logic [CNT_W-1:0] ded_cnt
);

  logic adv;

  // One enable for the whole pipe: it moves only when the
  // output register is empty or being drained this cycle.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic       syn_1, syn_2, syn_4, syn_8, par;

  assign syn_1 = in_code[1] ^ in_code[3] ^ in_code[5]
               ^ in_code[7] ^ in_code[9] ^ in_code[11];
  assign syn_2 = in_code[2] ^ in_code[3] ^ in_code[6]
               ^ in_code[7] ^ in_code[10] ^ in_code[11];
  assign syn_4 = in_code[4] ^ in_code[5] ^ in_code[6]
               ^ in_code[7] ^ in_code[12];
  assign syn_8 = in_code[8] ^ in_code[9] ^ in_code[10]
               ^ in_code[11] ^ in_code[12];
  assign par   = ^in_code;

  logic        s1_valid;
  logic [12:0] s1_code;
  logic [3:0]  s1_syn;
  logic        s1_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_p     <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_code  <= in_code;
      s1_syn   <= {syn_8, syn_4, syn_2, syn_1};
      s1_p     <= par;
    end
  end

  logic        single;
  logic        ded_c;
  logic [12:0] flip;
  logic [12:0] fixed;
  logic [7:0]  data_c;

  // Odd overall parity with a syndrome naming a real bit is a
  // single error; syndrome 0 then points at the parity bit itself.
  assign single = s1_p && (s1_syn <= 4'd12);
  assign ded_c  = (!s1_p && (s1_syn != 4'd0))
               || (s1_p && (s1_syn > 4'd12));
  assign flip   = single ? (13'd1 << s1_syn) : 13'd0;
  assign fixed  = s1_code ^ flip;
  assign data_c = {fixed[12], fixed[11], fixed[10], fixed[9],
                   fixed[7], fixed[6], fixed[5], fixed[3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sec      <= 1'b0;
      out_ded      <= 1'b0;
      out_syndrome <= '0;
    end else if (adv) begin
      out_valid    <= s1_valid;
      out_data     <= data_c;
      out_sec      <= single;
      out_ded      <= ded_c;
      out_syndrome <= s1_syn;
    end
  end

`ifdef HSIAO_ERR_CNT_EN
  logic out_hs;

  assign out_hs = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (cnt_clr) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else begin
      if (out_hs && out_sec && !(&sec_cnt))
        sec_cnt <= sec_cnt + CNT_W'(1);
      if (out_hs && out_ded && !(&ded_cnt))
        ded_cnt <= ded_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign sec_cnt        = '0;
  assign ded_cnt        = '0;
`endif

endmodule

// File: doc/hsiao_code_decoder.md
HSIAO_CODE_DECODER -- requirements
Module: hsiao_code_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the error-counter width in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_code is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts in_code this cycle.
REQ-006 SHALL have port in_code, input, 13 bits: the received codeword. Data sits at bits 12,11,10,9,7,6,5,3 (data[7:0] MSB first), check bits at 8,4,2,1, and overall even parity at bit 0.
REQ-007 SHALL have port out_valid, output, 1 bit: the output result is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-009 SHALL have port out_data, output, 8 bits: the decoded, corrected data.
REQ-010 SHALL have port out_sec, output, 1 bit: a single error was corrected.
REQ-011 SHALL have port out_ded, output, 1 bit: an uncorrectable error was detected.
REQ-012 SHALL have port out_syndrome, output, 4 bits: {s8,s4,s2,s1}.
REQ-013 SHALL have port cnt_clr, input, 1 bit: synchronous clear of both counters.
REQ-014 SHALL have port sec_cnt, output, CNT_W bits: count of corrected words.
REQ-015 SHALL have port ded_cnt, output, CNT_W bits: count of uncorrectable words.

Function
REQ-016 SHALL compute the syndrome bits as follows: s1 = XOR of bits 1,3,5,7,9,11; s2 = XOR of bits 2,3,6,7,10,11; s4 = XOR of bits 4,5,6,7,12; s8 = XOR of bits 8,9,10,11,12; p = XOR of bits 12..0.
REQ-017 SHALL classify each word as follows: s=0, p=0 means clean; p=1 with s<=12 means single error at position s (s=0 means bit 0), which is flipped before data extraction and sets out_sec; p=0 with s!=0 sets out_ded; p=1 with s in 13..15 also sets out_ded.
REQ-018 SHALL, on out_ded, output uncorrected raw data bits, and SHALL never assert out_sec and out_ded together.
REQ-019 SHALL be a 2-stage pipeline. Stage 1 registers the code, syndrome and p. Stage 2 registers the corrected data and flags. Latency is 2 cycles from input handshake to out_valid when unstalled.
REQ-020 SHALL use a global advance enable, adv = !out_valid | out_ready, with in_ready = adv. When adv=0, both stages hold their contents.
REQ-021 SHALL transfer data only when in_valid&in_ready (input) or out_valid&out_ready (output). out_data, flags and syndrome SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 SHALL sustain 1 word/cycle throughput with out_ready held high, with results emitted in input order and no loss or duplication.
REQ-023 SHALL propagate empty stages as bubbles (valid bit 0).
REQ-024 SHALL increment sec_cnt or ded_cnt on each output handshake carrying the respective flag.
REQ-025 SHALL saturate each counter at all-ones with no wrap.
REQ-026 SHALL give cnt_clr priority over a simultaneous increment: the counter becomes 0 and that event is dropped.

Reset
REQ-027 SHALL, while rst_n=0, clear both stage valid bits, out_valid, out_data, out_sec, out_ded, out_syndrome, sec_cnt and ded_cnt to 0.
REQ-028 SHALL hold in_ready at 1 during reset (adv is true when out_valid=0), while discarding inputs presented during reset.
REQ-029 SHALL, when reset is asserted mid-stream, discard in-flight words with no output handshake and no count change.

Configuration
REQ-030 SHALL, with HSIAO_ERR_CNT_EN defined, implement the counters per REQ-024..026.
REQ-031 SHALL, without HSIAO_ERR_CNT_EN, remove the counter logic, drive sec_cnt and ded_cnt constant 0, and ignore cnt_clr; all other behaviour is unchanged.

Verification
REQ-032 SHALL cover: in_code 0x1EEE, out_ready=1 -> two cycles later out_data=0xFF, out_sec=0, out_ded=0, out_syndrome=0.
REQ-033 SHALL cover: 0x1EAE (bit 6 flipped) -> out_data=0xFF, out_sec=1, out_syndrome=6, sec_cnt increments by 1.
REQ-034 SHALL cover: 0x1EEF (bit 0 flipped) -> out_data=0xFF, out_sec=1, out_syndrome=0.
REQ-035 SHALL cover: 0x1EED (bits 0 and 1 flipped) -> out_ded=1, out_sec=0, out_syndrome=1, out_data=0xFF, ded_cnt increments by 1.
REQ-036 SHALL cover: 3 back-to-back words with out_ready=0 for 5 cycles -> in_ready drops once both stages are full, out_data held stable, then all 3 delivered in order after out_ready=1.
REQ-037 SHALL cover: with CNT_W=2, 5 single-error words -> sec_cnt=3 (saturated); then cnt_clr with a concurrent single-error handshake -> sec_cnt=0.
